pl_ctrl_pipe: RTL
=================

Name: pl_ctrl_pipe

Overview:
- Pipelined successor to the single-cycle control decoder.
- Decodes the ID-stage instruction (opcode, funct3, funct7[5]) into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches/jumps in EX from ALU flags, detects load-use hazards, and emits stall/flush and PC-select to the datapath.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_AW, 5, register address width (rd/rs1/rs2).
- ALUCTRL_W, 4, width of ALU control output.
- CNT_W, 16, width of each event counter.
- LOAD_USE_EN, 1, 1 = load-use hazard detection enabled; 0 = stall_o tied 0.

Ports:
- clk  in  1  clock; all registers update on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_id  in  32  instruction in ID stage.
- valid_id  in  1  instr_id is a real instruction.
- freeze_i  in  1  external hold (memory wait); all stage registers and counters hold.
- zero_ex  in  1  ALU ZeroFlag for EX instruction.
- neg_ex  in  1  signed less-than result for EX instruction.
- ult_ex  in  1  unsigned less-than for EX instruction.
- stall_o  out  1  load-use stall; datapath holds PC and IF/ID.
- flush_o  out  1  control-flow redirect; datapath squashes IF/ID.
- pc_src_o  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result (JALR).
- illegal_o  out  1  ID opcode unrecognised while valid_id.
- imm_src_o  out  3  ID-stage immediate select: I 000, S 001, B 010, U 011, J 100.
- ex_alu_src_o  out  1  EX: B operand is immediate.
- ex_alu_ctrl_o  out  ALUCTRL_W  EX: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10.
- mem_write_o  out  1  MEM: store enable.
- wb_reg_write_o  out  1  WB: register write enable.
- wb_result_src_o  out  2  WB: 00 ALU, 01 load data, 10 PC+4, 11 PC+imm (AUIPC).
- wb_rd_o  out  REG_AW  WB destination register.
- stall_cnt_o  out  CNT_W  cycles with stall_o = 1.
- flush_cnt_o  out  CNT_W  cycles with flush_o = 1.

Behaviour:
- Reset: all stage valid bits 0, all registered controls 0, counters 0. Consequently stall_o = 0, flush_o = 0, pc_src_o = 00, all outputs 0.
- Decode is combinational in ID; opcodes handled: R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC.
- R-type ALU control is taken from funct3/funct7[5]. I-ALU uses funct3, with funct7[5] used only for SRAI.
- Loads, stores, AUIPC, JAL and JALR → ADD. Branch → SUB. LUI → PASSB.
- Unknown opcode with valid_id: illegal_o = 1 and a bubble is inserted (valid = 0, no writes).
- rs2 counts as used only for R, store and branch.
- Bubble: every stage with valid = 0 forces MemWrite = 0, RegWrite = 0 and branch/jump = 0 on its outputs.
- Load-use: asserted when EX is a valid load, rd_ex != 0, and rd_ex equals rs1_id, or equals rs2_id with rs2 used. Then:
  - stall_o = 1;
  - ID/EX loads a bubble;
  - EX/MEM and MEM/WB advance normally.
- Branch taken in EX (valid only):
  - BEQ: zero; BNE: !zero.
  - BLT: neg; BGE: !neg.
  - BLTU: ult; BGEU: !ult.
  - JAL and JALR are always taken.
- On taken: flush_o = 1, pc_src_o = 01 (10 for JALR), ID/EX loads a bubble next edge. Latency is one cycle (combinational in EX); the branch penalty is 2 instructions.
- Priority: flush_o forces stall_o = 0, because a squashed ID instruction cannot stall.
- freeze_i = 1:
  - all stage registers and counters hold;
  - stall_o, flush_o and pc_src_o are forced 0/00.
  - A pending EX branch is re-evaluated on the first unfrozen cycle.
- Counters increment by 1 per cycle of their event and saturate at 2^CNT_W−1 (no wrap).
- Reset asserted mid-operation clears all stages immediately (asynchronous). The in-flight instructions are lost with no writes.
- rd = 0 writes pass through, but never create hazards.

Test Plan:
- Reset: hold rst_n = 0 mid-stream, then release → all outputs 0 on the same cycle, counters 0, first valid instruction reaches WB 3 edges after entering ID.
- Load-use: lw x5,0(x1) then add x6,x5,x2 →
  - stall_o = 1 for exactly 1 cycle and a bubble in EX;
  - add writes x6 in WB two cycles after the lw;
  - stall_cnt_o = 1.
- Branch: beq with zero_ex = 1 → flush_o = 1, pc_src_o = 01 for 1 cycle, following ID instruction never reaches WB. With zero_ex = 0 → flush_o = 0.
- Branch matrix: sweep bne/blt/bge/bltu/bgeu over all 8 flag combinations → taken exactly as the rules; JALR → pc_src_o = 10, wb_result_src_o = 10.
- Flush beats stall: EX = taken branch, ID = instruction using load rd_ex → flush_o = 1, stall_o = 0, flush_cnt_o +1, stall_cnt_o unchanged.
- Freeze plus saturation: freeze_i = 1 during a taken branch → flush_o = 0 and state held, then flush on release. With CNT_W = 2, 5 stalls → stall_cnt_o = 3.

Source files
------------

// File: rtl/pl_ctrl_pipe.sv
// Pipelined control unit: decodes the ID instruction into a control bundle, carries it
// through ID/EX, EX/MEM and MEM/WB, resolves branches in EX and detects load-use hazards.
module pl_ctrl_pipe #(
    parameter int REG_AW      = 5,
    parameter int ALUCTRL_W   = 4,
    parameter int CNT_W       = 16,
    parameter int LOAD_USE_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_id,
    input  logic                 valid_id,
    input  logic                 freeze_i,
    input  logic                 zero_ex,
    input  logic                 neg_ex,
    input  logic                 ult_ex,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [1:0]           pc_src_o,
    output logic                 illegal_o,
    output logic [2:0]           imm_src_o,
    output logic                 ex_alu_src_o,
    output logic [ALUCTRL_W-1:0] ex_alu_ctrl_o,
    output logic                 mem_write_o,
    output logic                 wb_reg_write_o,
    output logic [1:0]           wb_result_src_o,
    output logic [REG_AW-1:0]    wb_rd_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA   = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT   = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(10);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_PCI  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem_read;
        logic                 branch;
        logic                 jal;
        logic                 jalr;
        logic [2:0]           funct3;
        logic                 alu_src;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [1:0]           result_src;
        logic [REG_AW-1:0]    rd;
    } ctrl_t;

    ctrl_t id_ex, ex_mem, mem_wb;
    ctrl_t dec;
    logic  known, rs2_used, br_cond, taken, load_use;
    logic  [2:0] imm_sel;

    wire [REG_AW-1:0] rs1_id = instr_id[15 +: REG_AW];
    wire [REG_AW-1:0] rs2_id = instr_id[20 +: REG_AW];
    wire [2:0]        f3_id  = instr_id[14:12];
    wire              f7b_id = instr_id[30];

    // funct7[5] selects SUB only for R-type; for immediates it only distinguishes SRAI.
    function automatic logic [ALUCTRL_W-1:0] alu_op(input logic [2:0] f3, input logic f7b,
                                                    input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec      = '0;
        known    = 1'b1;
        rs2_used = 1'b0;
        imm_sel  = IMM_I;
        case (instr_id[6:0])
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_op(f3_id, f7b_id, 1'b1);
                rs2_used      = 1'b1;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_op(f3_id, f7b_id, 1'b0);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_LOAD;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                rs2_used      = 1'b1;
                imm_sel       = IMM_S;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                rs2_used     = 1'b1;
                imm_sel      = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jal        = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
                imm_sel        = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
                imm_sel       = IMM_U;
            end
            OP_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PCI;
                imm_sel        = IMM_U;
            end
            default: known = 1'b0;
        endcase
        dec.funct3 = f3_id;
        dec.rd     = instr_id[7 +: REG_AW];
        dec.valid  = 1'b1;
        // Empty slots and unknown opcodes travel as an all-zero bubble.
        if (!(valid_id && known)) dec = '0;
    end

    assign illegal_o = valid_id && !known;
    assign imm_src_o = valid_id ? imm_sel : 3'b000;

    always_comb begin
        br_cond = 1'b0;
        case (id_ex.funct3)
            3'b000:  br_cond = zero_ex;
            3'b001:  br_cond = !zero_ex;
            3'b100:  br_cond = neg_ex;
            3'b101:  br_cond = !neg_ex;
            3'b110:  br_cond = ult_ex;
            3'b111:  br_cond = !ult_ex;
            default: br_cond = 1'b0;
        endcase
    end

    assign taken    = id_ex.valid && (id_ex.jal || id_ex.jalr || (id_ex.branch && br_cond));
    assign load_use = (LOAD_USE_EN != 0) && id_ex.valid && id_ex.mem_read && (id_ex.rd != '0) &&
                      ((id_ex.rd == rs1_id) || (rs2_used && (id_ex.rd == rs2_id)));

    // A redirect squashes the ID instruction, so it can never also stall.
    assign flush_o  = taken && !freeze_i;
    assign stall_o  = load_use && !taken && !freeze_i;
    assign pc_src_o = !flush_o ? 2'b00 : (id_ex.jalr ? 2'b10 : 2'b01);

    // NOTE: state registers use non-blocking assignments so all stages sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (!freeze_i) begin
            id_ex  <= (stall_o || flush_o) ? '0 : dec;
            ex_mem <= id_ex;
            mem_wb <= ex_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (!freeze_i) begin
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

    assign ex_alu_src_o    = id_ex.valid && id_ex.alu_src;
    assign ex_alu_ctrl_o   = id_ex.valid ? id_ex.alu_ctrl : ALU_ADD;
    assign mem_write_o     = ex_mem.valid && ex_mem.mem_write;
    assign wb_reg_write_o  = mem_wb.valid && mem_wb.reg_write;
    assign wb_result_src_o = mem_wb.valid ? mem_wb.result_src : RES_ALU;
    assign wb_rd_o         = mem_wb.valid ? mem_wb.rd : '0;

    wire unused_ok = &{1'b0, instr_id[31], instr_id[29:25], mem_wb};

endmodule
